// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - ALU, branch compare and data-memory bridge front end
module exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] f_rd2,
    input  logic [3:0]  aluop,
    input  logic [4:0]  sa,
    input  logic [2:0]  branchType,
    input  logic        memWrite,
    input  logic        isDMByte,
    input  logic        isDMHalf,
    input  logic [31:0] br_rdata,
    output logic [31:0] C,
    output logic [31:0] sum,
    output logic        zero,
    output logic        branchAvail,
    output logic [31:0] br_addr,
    output logic [31:0] br_wdata,
    output logic        br_we,
    output logic [3:0]  br_be,
    output logic [31:0] DMout
);

    logic [4:0] vshamt;
    logic       a_is_zero;
    logic       a_is_neg;

    assign vshamt    = A[4:0];
    assign sum       = A + B;
    assign zero      = (C == 32'h0);
    assign a_is_zero = (A == 32'h0);
    assign a_is_neg  = A[31];

    always_comb begin
        C = 32'h0;
        case (aluop)
            4'd0:  C = A + B;
            4'd1:  C = A - B;
            4'd2:  C = A & B;
            4'd3:  C = A | B;
            4'd4:  C = A ^ B;
            4'd5:  C = ~(A | B);
            4'd6:  C = B << sa;
            4'd7:  C = B >> sa;
            4'd8:  C = $signed(B) >>> sa;
            4'd9:  C = B << vshamt;
            4'd10: C = B >> vshamt;
            4'd11: C = $signed(B) >>> vshamt;
            4'd12: C = {B[15:0], 16'h0};
            4'd13: C = {31'h0, $signed(A) < $signed(B)};
            4'd14: C = {31'h0, A < B};
            default: C = B;
        endcase
    end

    always_comb begin
        branchAvail = 1'b0;
        case (branchType)
            3'd1: branchAvail = (A == B);
            3'd2: branchAvail = (A != B);
            3'd3: branchAvail = a_is_neg | a_is_zero;
            3'd4: branchAvail = ~a_is_neg & ~a_is_zero;
            3'd5: branchAvail = a_is_neg;
            3'd6: branchAvail = ~a_is_neg;
            3'd7: branchAvail = 1'b1;
            default: branchAvail = 1'b0;
        endcase
    end

    // Byte size wins over halfword when a decoder asserts both.
    always_comb begin
        if (isDMByte) begin
            br_be    = 4'b0001 << sum[1:0];
            br_wdata = {4{f_rd2[7:0]}};
        end else if (isDMHalf) begin
            br_be    = sum[1] ? 4'b1100 : 4'b0011;
            br_wdata = {2{f_rd2[15:0]}};
        end else begin
            br_be    = 4'b1111;
            br_wdata = f_rd2;
        end
    end

    assign br_addr = {sum[31:2], 2'b00};
    assign br_we   = memWrite;

    // Raw word capture; lane selection and extension happen downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DMout <= 32'h0;
        end else begin
            DMout <= br_rdata;
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - self-checking bench for exec_unit against an arithmetic reference model
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, B, f_rd2, br_rdata;
    logic [3:0]  aluop;
    logic [4:0]  sa;
    logic [2:0]  branchType;
    logic        memWrite, isDMByte, isDMHalf;
    logic [31:0] C, sum, br_addr, br_wdata, DMout;
    logic        zero, branchAvail, br_we;
    logic [3:0]  br_be;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exec_unit dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .f_rd2(f_rd2), .aluop(aluop), .sa(sa),
        .branchType(branchType), .memWrite(memWrite), .isDMByte(isDMByte),
        .isDMHalf(isDMHalf), .br_rdata(br_rdata), .C(C), .sum(sum), .zero(zero),
        .branchAvail(branchAvail), .br_addr(br_addr), .br_wdata(br_wdata),
        .br_we(br_we), .br_be(br_be), .DMout(DMout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a,
                                             input logic [31:0] b, input int s);
        logic [63:0] p;
        logic [63:0] prod;
        int unsigned shamt;
        longint sa_l, sb_l;
        shamt = (op >= 9 && op <= 11) ? int'(a % 32) : s;
        p = 64'd1;
        for (int i = 0; i < 32; i++) if (i < int'(shamt)) p = p * 2;
        sa_l = longint'($signed(a));
        sb_l = longint'($signed(b));
        prod = {32'h0, b} * p;
        case (op)
            0:  return a + b;
            1:  return a + (~b + 1);
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return ~(a | b);
            6, 9:  return prod[31:0];
            7, 10: return 32'({32'h0, b} / p);
            8, 11: return b[31] ? ~32'({32'h0, ~b} / p) : 32'({32'h0, b} / p);
            12: return b * 32'd65536;
            13: return (sa_l < sb_l) ? 32'd1 : 32'd0;
            14: return ({32'h0, a} < {32'h0, b}) ? 32'd1 : 32'd0;
            default: return b;
        endcase
    endfunction

    function automatic logic br_ref(input int bt, input logic [31:0] a, input logic [31:0] b);
        longint va;
        va = longint'($signed(a));
        case (bt)
            1: return a == b;
            2: return a != b;
            3: return va <= 0;
            4: return va > 0;
            5: return va < 0;
            6: return va >= 0;
            7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic mem_ref(input logic [31:0] addr, input logic [31:0] d, input logic byt,
                           input logic half, output logic [3:0] be, output logic [31:0] wd);
        int lane;
        lane = int'(addr % 4);
        be = 4'b0000;
        if (byt) begin
            be[lane] = 1'b1;
            wd = d[7:0] * 32'h01010101;
        end else if (half) begin
            if (lane >= 2) be = 4'b1100; else be = 4'b0011;
            wd = d[15:0] * 32'h00010001;
        end else begin
            be = 4'b1111;
            wd = d;
        end
    endtask

    task automatic drive(input int op, input logic [31:0] a, input logic [31:0] b, input int s);
        aluop = 4'(op); A = a; B = b; sa = 5'(s);
        #1;
    endtask

    initial begin
        logic [31:0] e, a, b, d, prev;
        logic [3:0]  ebe;
        int op, s, bt;

        rst = 1'b0; A = 32'h0; B = 32'h0; f_rd2 = 32'h0; aluop = 4'd0; sa = 5'd0;
        branchType = 3'd0; memWrite = 1'b0; isDMByte = 1'b0; isDMHalf = 1'b0;
        br_rdata = 32'h12345678;
        #1;
        check("reset_dmout", DMout, 32'h0);
        drive(0, 32'h10, 32'h22, 0);
        check("reset_comb_sum", sum, 32'h32);
        check("reset_comb_c", C, 32'h32);
        @(posedge clk); #1;
        check("reset_hold_dmout", DMout, 32'h0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("resume_dmout", DMout, 32'h12345678);

        drive(1, 5, 5, 0);
        check("sub_c", C, 0); check("sub_zero", zero, 1);
        drive(13, 32'hFFFFFFFF, 1, 0); check("slt", C, 1);
        drive(14, 32'hFFFFFFFF, 1, 0); check("sltu", C, 0);
        drive(8, 0, 32'h80000000, 4); check("sra", C, 32'hF8000000);
        drive(9, 32'h21, 1, 0); check("sllv", C, 2);
        drive(12, 0, 32'h1234, 0); check("lui", C, 32'h12340000);

        A = 0; B = 7; branchType = 3; #1; check("blez_0", branchAvail, 1);
        branchType = 4; #1; check("bgtz_0", branchAvail, 0);
        A = 32'h80000000; branchType = 6; #1; check("bgez_min", branchAvail, 0);
        A = 32'h55; B = 32'h55; branchType = 2; #1; check("bne_eq", branchAvail, 0);
        branchType = 0; #1; check("none", branchAvail, 0);

        drive(0, 32'h1000, 3, 0);
        f_rd2 = 32'hAB; isDMByte = 1; memWrite = 1; #1;
        check("byte_sum", sum, 32'h1003); check("byte_addr", br_addr, 32'h1000);
        check("byte_be", br_be, 4'b1000); check("byte_wdata", br_wdata, 32'hABABABAB);
        check("byte_we", br_we, 1);
        isDMByte = 0; isDMHalf = 1; f_rd2 = 32'hCAFE1357; B = 2; #1;
        check("half_be_hi", br_be, 4'b1100); check("half_wdata", br_wdata, 32'h13571357);
        B = 1; #1; check("half_be_lo", br_be, 4'b0011);
        isDMByte = 1; #1; check("byte_prio", br_be, 4'b0010);
        isDMByte = 0; isDMHalf = 0; #1; check("word_be", br_be, 4'b1111);

        @(negedge clk); br_rdata = 32'hDEADBEEF;
        @(posedge clk); #1; check("read_lat", DMout, 32'hDEADBEEF);
        @(negedge clk); br_rdata = 32'h0BADF00D;
        @(posedge clk); #1; check("read_during_we", DMout, 32'h0BADF00D);
        #2; rst = 1'b0; #1; check("async_reset", DMout, 32'h0);
        @(negedge clk); rst = 1'b1; br_rdata = 32'h600DCAFE;
        @(posedge clk); #1; check("post_reset_cap", DMout, 32'h600DCAFE);

        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 15)); s = int'($urandom_range(0, 31));
            a = $urandom; b = $urandom;
            if (i % 8 == 0) b = a;
            drive(op, a, b, s);
            e = alu_ref(op, a, b, s);
            check($sformatf("rand_alu_op%0d", op), C, e);
            check("rand_zero", zero, e == 0);
            check("rand_sum", sum, a + b);
            bt = int'($urandom_range(0, 7));
            if (i % 5 == 0) A = 0;
            branchType = 3'(bt); #1;
            check($sformatf("rand_br%0d", bt), branchAvail, br_ref(bt, A, B));
        end

        for (int i = 0; i < 100; i++) begin
            a = $urandom; b = $urandom; d = $urandom;
            A = a; B = b; f_rd2 = d; isDMByte = 1'($urandom); isDMHalf = 1'($urandom);
            memWrite = 1'($urandom);
            @(negedge clk); prev = $urandom; br_rdata = prev; #1;
            mem_ref(a + b, d, isDMByte, isDMHalf, ebe, e);
            check("rand_be", br_be, ebe);
            check("rand_wdata", br_wdata, e);
            check("rand_addr", br_addr, (a + b) - ((a + b) % 4));
            check("rand_we", br_we, memWrite);
            @(posedge clk); #1;
            check("rand_dmout", DMout, prev);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The block SHALL expose these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- A  in  32  operand A (forwarded rs value)
- B  in  32  operand B (forwarded rt value or extended immediate)
- f_rd2  in  32  store data (forwarded rt value)
- aluop  in  4  ALU function select
- sa  in  5  shift amount field
- branchType  in  3  branch condition select
- memWrite  in  1  store request
- isDMByte  in  1  byte-size access
- isDMHalf  in  1  halfword-size access
- br_rdata  in  32  bridge read data, combinational for the current br_addr
- C  out  32  ALU result
- sum  out  32  A+B, the access address
- zero  out  1  C equals 0
- branchAvail  out  1  branch condition true
- br_addr  out  32  word-aligned bridge address
- br_wdata  out  32  lane-replicated store data
- br_we  out  1  bridge write enable
- br_be  out  4  byte enables
- DMout  out  32  registered read word

Function
REQ-002 C, sum, zero, branchAvail and all br_* outputs SHALL be purely combinational.
REQ-003 aluop encoding SHALL be:
- 0 ADD A+B; 1 SUB A-B
- 2 AND; 3 OR; 4 XOR; 5 NOR
- 6 SLL B<<sa; 7 SRL B>>sa logical; 8 SRA B>>>sa arithmetic
- 9 SLLV B<<A[4:0]; 10 SRLV; 11 SRAV (shift by A[4:0])
- 12 LUI {B[15:0],16'h0}
- 13 SLT signed A<B ? 1 : 0; 14 SLTU unsigned A<B ? 1 : 0
- 15 PASS B
REQ-004 All arithmetic SHALL be 32-bit modulo with no overflow flag or trap; carries out of bit 31 are discarded.
REQ-005 sum SHALL always equal A+B modulo 2^32, independent of aluop.
REQ-006 zero SHALL be 1 exactly when C==32'h0.
REQ-007 branchType encoding SHALL be (A and B treated as signed where relevant):
- 0 none -> 0
- 1 BEQ A==B; 2 BNE A!=B
- 3 BLEZ A<=0; 4 BGTZ A>0; 5 BLTZ A<0; 6 BGEZ A>=0
- 7 unconditional -> 1
REQ-008 br_addr SHALL be {sum[31:2],2'b00}.
REQ-009 br_be SHALL be:
- byte access: 4'b0001<<sum[1:0]
- half access: sum[1] ? 4'b1100 : 4'b0011, with sum[0] ignored
- otherwise (word): 4'b1111, with sum[1:0] ignored
REQ-010 isDMByte SHALL take priority over isDMHalf when both are set.
REQ-011 br_wdata SHALL be:
- byte: {4{f_rd2[7:0]}}
- half: {2{f_rd2[15:0]}}
- word: f_rd2
REQ-012 br_we SHALL equal memWrite; br_be and br_addr SHALL be driven identically for reads and writes.
REQ-013 DMout SHALL capture br_rdata on every rising clk edge, giving 1-cycle latency, and SHALL hold the raw word with no lane extraction or sign extension.
REQ-014 DMout SHALL update even while memWrite=1, capturing whatever br_rdata is presented.

Reset
REQ-015 While rst=0, DMout SHALL be forced to 32'h0 immediately, independent of clk.
REQ-016 After rst rises, DMout SHALL resume capture at the first rising clk edge.
REQ-017 Reset SHALL NOT affect any combinational output.

Verification
REQ-018 ALU checks:
- aluop=1, A=5, B=5 -> C=0, zero=1
- aluop=13, A=32'hFFFFFFFF, B=1 -> C=1
- aluop=14 with the same operands -> C=0
REQ-019 Shift checks:
- aluop=8, B=32'h80000000, sa=4 -> C=32'hF8000000
- aluop=9, A=32'h21, B=1 -> C=2 (shift by A[4:0]=1)
- aluop=12, B=32'h1234 -> C=32'h12340000
REQ-020 Branch checks, each condition at its boundary:
- branchType=3, A=0 -> 1
- branchType=4, A=0 -> 0
- branchType=6, A=32'h80000000 -> 0
- branchType=2, A=B -> 0
- branchType=0 -> 0 for any operands
REQ-021 Byte store: A=32'h1000, B=3, f_rd2=32'hAB, isDMByte=1, memWrite=1 -> sum=32'h1003, br_addr=32'h1000, br_be=4'b1000, br_wdata=32'hABABABAB, br_we=1.
REQ-022 Half store: sum=32'h1002, isDMHalf=1 -> br_be=4'b1100, br_wdata={2{f_rd2[15:0]}}; with sum=32'h1001 -> br_be=4'b0011.
REQ-023 Read and reset: br_rdata=32'hDEADBEEF -> DMout=32'hDEADBEEF one edge later; rst=0 asserted between clk edges -> DMout=0 immediately.
